bcd_to_bin: RTL and testbench
=============================

Name: bcd_to_bin

Overview:
Sequential BCD-to-binary converter; the inverse of the existing binary-to-BCD conversion path that drives the seven-segment displays.
- Accepts a packed multi-digit BCD word and produces its unsigned binary value using the iterative shift-right / subtract-3 algorithm (reverse double-dabble), one shift per clock.
- Sits between switch/keypad BCD entry and binary arithmetic logic on the DE0 board.
- Uses a start/busy/done handshake and flags illegal digits.

Parameters:
- DIGITS, 3, number of BCD digits on the input (4*DIGITS input bits).
- BIN_W, 10, binary result width; must satisfy 2^BIN_W > 10^DIGITS - 1, and this also sets the shift count.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE or DONE.
- bcd_in  input  4*DIGITS  packed BCD, digit 0 in [3:0].
- busy  output  1  high while a conversion is in progress (SHIFT state).
- done  output  1  single-cycle pulse when the result is valid.
- err  output  1  set with done when any input digit is greater than 9; held until the next accepted start.
- bin_out  output  BIN_W  result; held stable from done until the next accepted start.

Behaviour:
- States: IDLE, SHIFT, DONE.
- Reset (synchronous, rst=1 at a rising edge) values:
  - state = IDLE.
  - busy = 0, done = 0, err = 0, bin_out = 0.
  - Internal BCD shift register and counter cleared.
  - Applies mid-conversion as well; the in-flight conversion is abandoned with no done pulse.
- IDLE, start=1:
  - Latch bcd_in into the BCD register and clear the binary register and err.
  - Check every digit.
  - If any digit is greater than 9: go to DONE with err=1 and bin_out=0; done rises the next cycle, so latency is 1.
  - Otherwise: load counter = BIN_W and go to SHIFT.
- SHIFT, one iteration per cycle:
  - Shift the concatenation {bcd_reg, bin_reg} right by one bit.
  - Then, for each 4-bit digit of the shifted bcd_reg, subtract 3 if the digit is 8 or more.
  - Decrement the counter.
  - When the counter reaches 1 on this cycle, go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - bin_out is updated from bin_reg on entry and then held.
  - The next state is IDLE, unless start=1 in DONE; that start is accepted exactly as in IDLE (back-to-back conversions).
- Latency: start sampled at edge N gives done=1 during cycle N+BIN_W+1 (11 cycles with defaults).
- busy is high from the cycle after start through the last SHIFT cycle. busy and done are never high together.
- start=1 while busy is ignored. bcd_in changes during SHIFT have no effect.
- Width rules:
  - bin_out is unsigned.
  - Overflow is impossible when the BIN_W constraint holds.
  - After BIN_W shifts, bcd_reg must be zero; a nonzero remainder is a design error and is checked by assertion, not flagged on err.
- bin_out keeps its previous value while busy. On an err conversion bin_out is forced to 0.

Decomposition:
- Shared package bcd_pkg holds:
  - the state encoding enum for IDLE, SHIFT and DONE;
  - localparam BCD_DIGIT_MAX = 9;
  - the subtract threshold 8 and adjust value 3;
  - a function returning the minimum binary width for a given number of digits, used by an elaboration-time check of BIN_W.
- One natural sub-module: bcd_digit_adj.
  - Combinational 4-bit "if digit is 8 or more, subtract 3".
  - Instantiated DIGITS times in a generate loop.
- The FSM, counter and registers stay in bcd_to_bin.

Test Plan:
- Reset then bcd_in=12'h255, start pulse -> busy for 10 cycles, done at cycle 11, bin_out=10'd255, err=0.
- bcd_in=12'h999 -> bin_out=10'd999 (10'b1111100111). bcd_in=12'h000 -> bin_out=0 after the same full latency.
- bcd_in=12'h1A3 -> done one cycle after start, err=1, bin_out=0, busy never asserted.
- Start with 12'h128; pulse start again and change bcd_in to 12'h777 mid-SHIFT -> both ignored, result 128. Then start=1 on the DONE cycle with 12'h042 -> second done 11 cycles later, bin_out=42.
- Assert rst at SHIFT cycle 5 of 12'h500 -> next cycle busy=0, done=0, bin_out=0, and no done pulse follows. A fresh start with 12'h007 yields 7.
- Random sweep of all 1000 legal inputs against a reference model -> exact match, with done pulse width exactly 1.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Includes the elaboration-time helper that sizes the binary result.
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ_VALUE  = 4'd3;

  // Smallest width w with 2^w > 10^digits - 1.
  function automatic int unsigned min_bin_width(input int unsigned digits);
    longint unsigned max_val = 64'd1;
    int unsigned     width   = 0;
    for (int unsigned i = 0; i < digits; i++) begin
      max_val = max_val * 64'd10;
    end
    max_val = max_val - 64'd1;
    for (int unsigned b = 0; b < 64; b++) begin
      if ((64'd1 << b) <= max_val) begin
        width = b + 1;
      end
    end
    return width;
  endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// Start/busy/done handshake and data bus of the BCD-to-binary converter.
interface bcd_to_bin_if #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
);

  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [BIN_W-1:0]      bin_out;

  modport master (
    output start,
    output bcd_in,
    input  busy,
    input  done,
    input  err,
    input  bin_out
  );

  modport slave (
    input  start,
    input  bcd_in,
    output busy,
    output done,
    output err,
    output bin_out
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of reverse double-dabble: digits of 8 or more
// lose 3 after the right shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= BCD_ADJ_THRESH) begin
      o_digit = i_digit - BCD_ADJ_VALUE;
    end
  end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift per clock)
// with start/busy/done handshake and illegal-digit flag.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  bcd_to_bin_if.slave  s_if
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W + 1);

  if (BIN_W < min_bin_width(DIGITS)) begin : g_bin_w_check
    $error("bcd_to_bin: BIN_W too small to hold the largest DIGITS-digit BCD value");
  end

  state_e            r_state, w_state_next;
  logic [BcdW-1:0]   r_bcd, w_bcd_sh, w_bcd_adj;
  logic [BIN_W-1:0]  r_bin, w_bin_sh, r_bin_out;
  logic [CntW-1:0]   r_cnt;
  logic              r_err;
  logic              w_bad;
  logic              w_accept;
  logic              w_last;

  assign {w_bcd_sh, w_bin_sh} = {r_bcd, r_bin} >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (w_bcd_sh[4*g +: 4]),
      .o_digit (w_bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (s_if.bcd_in[4*i +: 4] > BCD_DIGIT_MAX) begin
        w_bad = 1'b1;
      end
    end
  end

  assign w_accept = s_if.start && ((r_state == StIdle) || (r_state == StDone));
  assign w_last   = (r_state == StShift) && (r_cnt == CntW'(1));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (s_if.start) begin
          w_state_next = w_bad ? StDone : StShift;
        end else begin
          w_state_next = StIdle;
        end
      end
      StShift: begin
        if (w_last) begin
          w_state_next = StDone;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_bcd     <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_bin_out <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_bcd <= s_if.bcd_in;
        r_bin <= '0;
        r_err <= w_bad;
        r_cnt <= CntW'(BIN_W);
        // bin_out otherwise keeps the previous result until this one lands.
        if (w_bad) begin
          r_bin_out <= '0;
        end
      end else if (r_state == StShift) begin
        r_bcd <= w_bcd_adj;
        r_bin <= w_bin_sh;
        r_cnt <= r_cnt - CntW'(1);
        if (w_last) begin
          r_bin_out <= w_bin_sh;
        end
      end
    end
  end

  assign s_if.busy    = (r_state == StShift);
  assign s_if.done    = (r_state == StDone);
  assign s_if.err     = r_err;
  assign s_if.bin_out = r_bin_out;

  // Every BCD weight must have drained into the binary register by the last shift.
  assert property (@(posedge i_clk) disable iff (i_rst) w_last |-> (w_bcd_adj == '0));

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: vector table, handshake corner cases,
// and a shuffled sweep of all legal inputs plus random illegal ones.
module tb_bcd_to_bin;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned BIN_W  = 10;
  localparam int          MAX_WAIT = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  bcd_to_bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) u_if ();

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .s_if  (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bcd;
    logic [9:0]  bin;
    logic        err;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: decimal value from digit arithmetic, or error on any digit above 9.
  task automatic ref_model(input logic [11:0] bcd, output logic [9:0] bin, output logic err);
    int d0, d1, d2;
    d0 = int'(bcd[3:0]);
    d1 = int'(bcd[7:4]);
    d2 = int'(bcd[11:8]);
    err = (d0 > 9) || (d1 > 9) || (d2 > 9);
    bin = err ? 10'd0 : 10'(d2 * 100 + d1 * 10 + d0);
  endtask

  task automatic kick(input logic [11:0] bcd);
    u_if.start  = 1'b1;
    u_if.bcd_in = bcd;
    @(posedge clk); #1;
    u_if.start  = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat, output int busy_cnt,
                           output bit overlap);
    lat      = lat0;
    busy_cnt = 0;
    overlap  = 1'b0;
    forever begin
      if (u_if.busy) busy_cnt++;
      if (u_if.busy && u_if.done) overlap = 1'b1;
      if (u_if.done || lat >= MAX_WAIT) break;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One full conversion checked against the model, including done pulse width.
  task automatic run_and_check(input string tag, input logic [11:0] bcd);
    logic [9:0] exp_bin;
    logic       exp_err;
    int         lat, busy_cnt;
    bit         overlap;
    ref_model(bcd, exp_bin, exp_err);
    kick(bcd);
    wait_done(1, lat, busy_cnt, overlap);
    check({tag, " latency"}, lat, exp_err ? 1 : BIN_W + 1);
    check({tag, " bin_out"}, u_if.bin_out, exp_bin);
    check({tag, " err"}, u_if.err, exp_err);
    check({tag, " busy cycles"}, busy_cnt, exp_err ? 0 : BIN_W);
    check({tag, " busy/done overlap"}, overlap, 0);
    @(posedge clk); #1;
    check({tag, " done width"}, u_if.done, 0);
    check({tag, " err held"}, u_if.err, exp_err);
    check({tag, " bin_out held"}, u_if.bin_out, exp_bin);
  endtask

  initial begin
    vec_t        vecs[8];
    int          order[1000];
    int          lat, busy_cnt, tmp, j;
    bit          overlap, seen;
    logic [11:0] bcd;

    vecs[0] = '{bcd: 12'h255, bin: 10'd255, err: 1'b0, lat: 11};
    vecs[1] = '{bcd: 12'h999, bin: 10'd999, err: 1'b0, lat: 11};
    vecs[2] = '{bcd: 12'h000, bin: 10'd0,   err: 1'b0, lat: 11};
    vecs[3] = '{bcd: 12'h1A3, bin: 10'd0,   err: 1'b1, lat: 1};
    vecs[4] = '{bcd: 12'h010, bin: 10'd10,  err: 1'b0, lat: 11};
    vecs[5] = '{bcd: 12'h9F9, bin: 10'd0,   err: 1'b1, lat: 1};
    vecs[6] = '{bcd: 12'h512, bin: 10'd512, err: 1'b0, lat: 11};
    vecs[7] = '{bcd: 12'hF00, bin: 10'd0,   err: 1'b1, lat: 1};

    u_if.start  = 1'b0;
    u_if.bcd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", u_if.busy, 0);
    check("reset done", u_if.done, 0);
    check("reset err", u_if.err, 0);
    check("reset bin_out", u_if.bin_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      kick(vecs[i].bcd);
      wait_done(1, lat, busy_cnt, overlap);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d bin_out", i), u_if.bin_out, vecs[i].bin);
      check($sformatf("vec%0d err", i), u_if.err, vecs[i].err);
      check($sformatf("vec%0d busy cycles", i), busy_cnt, vecs[i].err ? 0 : BIN_W);
      check($sformatf("vec%0d overlap", i), overlap, 0);
      @(posedge clk); #1;
      check($sformatf("vec%0d done width", i), u_if.done, 0);
      check($sformatf("vec%0d err held", i), u_if.err, vecs[i].err);
    end

    // Start and bcd_in changes while busy must be ignored.
    kick(12'h128);
    repeat (3) begin @(posedge clk); #1; end
    u_if.start  = 1'b1;
    u_if.bcd_in = 12'h777;
    @(posedge clk); #1;
    u_if.start  = 1'b0;
    wait_done(5, lat, busy_cnt, overlap);
    check("ignore latency", lat, 11);
    check("ignore bin_out", u_if.bin_out, 128);
    // Back-to-back: start on the DONE cycle.
    kick(12'h042);
    check("b2b busy", u_if.busy, 1);
    check("b2b bin_out held while busy", u_if.bin_out, 128);
    wait_done(1, lat, busy_cnt, overlap);
    check("b2b latency", lat, 11);
    check("b2b bin_out", u_if.bin_out, 42);
    @(posedge clk); #1;

    // Reset in SHIFT cycle 5 abandons the conversion.
    kick(12'h500);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst busy", u_if.busy, 0);
    check("midrst done", u_if.done, 0);
    check("midrst bin_out", u_if.bin_out, 0);
    check("midrst err", u_if.err, 0);
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (u_if.done) seen = 1'b1;
    end
    check("midrst no done", seen, 0);
    run_and_check("post-reset 007", 12'h007);

    // All legal inputs in shuffled order.
    for (int i = 0; i < 1000; i++) order[i] = i;
    for (int i = 999; i > 0; i--) begin
      j        = int'($urandom_range(i, 0));
      tmp      = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < 1000; i++) begin
      bcd = {4'(order[i] / 100), 4'((order[i] / 10) % 10), 4'(order[i] % 10)};
      run_and_check($sformatf("sweep %03h", bcd), bcd);
    end

    // Random words, mostly containing illegal digits.
    for (int i = 0; i < 30; i++) begin
      bcd = 12'($urandom_range(4095, 0));
      run_and_check($sformatf("rand %03h", bcd), bcd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
